// File: rtl/pulse_train_pkg.sv
// Shared state encoding and mode constants for the pulse train generator.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_e;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_CONT  = 1'b1;

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down counter with zero-to-one load clamping; used for phase timing
// and for the burst pulse count.
module pulse_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? W'(1) : load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Set while the current unit is the last one before reaching zero.
    assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Burst / continuous pulse train generator triggered on a rising edge of `on`.
// Optional `abort` input is enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned BURST_W  = 4,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               on,
    input  logic               mode,
    input  logic [CNT_W-1:0]   delay,
    input  logic [CNT_W-1:0]   high_len,
    input  logic [CNT_W-1:0]   low_len,
    input  logic [BURST_W-1:0] count,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic               abort,
`endif
    output logic               signal,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic               on_q;
    logic               mode_q;
    logic [CNT_W-1:0]   high_q, low_q;
    logic               signal_q, busy_q, done_q, done_d;
    logic               trig, start;
    logic               ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0]   ph_val;
    logic               pc_load, pc_dec, pc_zero;
    logic               abort_hit;

`ifdef PULSE_TRAIN_ABORT_EN
    assign trig      = on & ~on_q & ~abort;
    assign abort_hit = abort & (state_q != IDLE);
`else
    assign trig      = on & ~on_q;
    assign abort_hit = 1'b0;
`endif

    // A trigger landing in the done cycle is dropped; `on` must fall and rise again.
    assign start = (state_q == IDLE) & trig & ~done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ph_load = 1'b0;
        ph_dec  = 1'b0;
        ph_val  = high_q;
        pc_load = 1'b0;
        pc_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_load = 1'b1;
                    ph_load = 1'b1;
                    if (delay != '0) begin
                        state_d = DELAY;
                        ph_val  = delay;
                    end else begin
                        state_d = HIGH;
                        ph_val  = high_len;
                    end
                end
            end
            DELAY: begin
                if (ph_zero) begin
                    state_d = HIGH;
                    ph_load = 1'b1;
                    ph_val  = high_q;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            HIGH: begin
                if (ph_zero) begin
                    if ((mode_q == MODE_BURST) ? !pc_zero : on) begin
                        state_d = LOW;
                        ph_load = 1'b1;
                        ph_val  = low_q;
                        pc_dec  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (ph_zero) begin
                    if ((mode_q == MODE_BURST) || on) begin
                        state_d = HIGH;
                        ph_load = 1'b1;
                        ph_val  = high_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
        endcase
        if (abort_hit) begin
            state_d = IDLE;
            done_d  = 1'b0;
            ph_load = 1'b0;
            ph_dec  = 1'b0;
            pc_load = 1'b0;
            pc_dec  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            on_q     <= 1'b0;
            mode_q   <= MODE_BURST;
            high_q   <= '0;
            low_q    <= '0;
            signal_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            on_q     <= on;
            signal_q <= (state_d == HIGH) ? ~IDLE_LVL : IDLE_LVL;
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
            if (start) begin
                mode_q <= mode;
                high_q <= high_len;
                low_q  <= low_len;
            end
        end
    end

    pulse_down_counter #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .dec_i      (ph_dec),
        .zero_o     (ph_zero)
    );

    pulse_down_counter #(
        .W (BURST_W)
    ) u_pulse_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (count),
        .dec_i      (pc_dec),
        .zero_o     (pc_zero)
    );

    assign signal = signal_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: per-cycle {signal,busy,done} scoreboard.
module tb_pulse_train_gen;

    logic       clock;
    logic       reset;
    logic       on;
    logic       mode;
    logic [7:0] delay;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [3:0] count;
    logic       abort;
    logic       signal;
    logic       busy;
    logic       done;

    int         checks;
    int         passed;
    logic [2:0] exp_q[$];
    logic [2:0] e;

    pulse_train_gen #(
        .CNT_W    (8),
        .BURST_W  (4),
        .IDLE_LVL (1'b0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .on       (on),
        .mode     (mode),
        .delay    (delay),
        .high_len (high_len),
        .low_len  (low_len),
        .count    (count),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort    (abort),
`endif
        .signal   (signal),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {signal,busy,done} per cycle; entry 0 is the cycle `on` rises.
    task automatic push_seq(input int d, input int h, input int l, input int n,
                            input int tail);
        int hh = (h == 0) ? 1 : h;
        int ll = (l == 0) ? 1 : l;
        int nn = (n == 0) ? 1 : n;
        exp_q.push_back(3'b000);
        repeat (d) exp_q.push_back(3'b010);
        for (int p = 0; p < nn; p++) begin
            repeat (hh) exp_q.push_back(3'b110);
            if (p < nn - 1) repeat (ll) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b001);
        repeat (tail) exp_q.push_back(3'b000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (signal !== 1'b0) $display("FAIL reset_signal: got %b want 0", signal);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_burst();
        mode = 1'b0; delay = 8'd0; high_len = 8'd3; low_len = 8'd2; count = 4'd3;
        push_seq(0, 3, 2, 3, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL burst cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
        end
        on = 1'b0;
    endtask

    task automatic test_clamp();
        mode = 1'b0; delay = 8'd5; high_len = 8'd0; low_len = 8'd0; count = 4'd0;
        push_seq(5, 0, 0, 0, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL clamp cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
        end
        on = 1'b0;
    endtask

    task automatic test_continuous();
        mode = 1'b1; delay = 8'd0; high_len = 8'd2; low_len = 8'd2; count = 4'd1;
        exp_q.push_back(3'b000);
        for (int c = 1; c <= 22; c++)
            exp_q.push_back((((c - 1) % 4) < 2) ? 3'b110 : 3'b010);
        exp_q.push_back(3'b001);
        repeat (2) exp_q.push_back(3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL cont cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
            if (i == 21) on = 1'b0;
        end
        // `on` drops during DELAY: one full HIGH still follows.
        delay = 8'd3; high_len = 8'd2; low_len = 8'd1;
        push_seq(3, 2, 1, 1, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL cont_delay cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
            if (i == 1) on = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; delay = 8'd0; high_len = 8'd2; low_len = 8'd2; count = 4'd4;
        push_seq(0, 2, 2, 4, 5);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL retrig cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            case (i)
                0, 5, 11, 14: on = 1'b1;
                3, 9, 13:     on = 1'b0;
                default: ;
            endcase
        end
        on = 1'b0;
        high_len = 8'd1; low_len = 8'd1; count = 4'd1;
        push_seq(0, 1, 1, 1, 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL fresh cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
        end
        on = 1'b0;
    endtask

    task automatic test_max_count();
        mode = 1'b0; delay = 8'd0; high_len = 8'd1; low_len = 8'd1; count = 4'd15;
        push_seq(0, 1, 1, 15, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL maxcnt cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
        end
        on = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 1'b0; delay = 8'd0; high_len = 8'd5; low_len = 8'd1; count = 4'd2;
        @(negedge clock);
        on = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (signal !== 1'b1) $display("FAIL pre_reset_high: got %b want 1", signal);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({signal, busy, done} !== 3'b000)
            $display("FAIL async_reset: got %b want 000", {signal, busy, done});
        else passed++;
        @(negedge clock);
        on = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        high_len = 8'd1; count = 4'd2;
        push_seq(0, 1, 1, 2, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL post_reset cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            if (i == 0) on = 1'b1;
        end
        on = 1'b0;
    endtask

`ifdef PULSE_TRAIN_ABORT_EN
    task automatic test_abort();
        mode = 1'b0; delay = 8'd0; high_len = 8'd2; low_len = 8'd2; count = 4'd5;
        exp_q.push_back(3'b000);
        repeat (2) exp_q.push_back(3'b110);
        repeat (2) exp_q.push_back(3'b010);
        exp_q.push_back(3'b110);
        repeat (7) exp_q.push_back(3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({signal, busy, done} !== e)
                $display("FAIL abort cyc %0d: got %b want %b", i, {signal, busy, done}, e);
            else passed++;
            case (i)
                0:  on = 1'b1;
                5:  abort = 1'b1;
                6:  abort = 1'b0;
                8:  on = 1'b0;
                9:  begin on = 1'b1; abort = 1'b1; end
                10: abort = 1'b0;
                default: ;
            endcase
        end
        on = 1'b0;
    endtask
`endif

    initial begin
        checks = 0; passed = 0;
        on = 1'b0; mode = 1'b0; delay = '0; high_len = '0; low_len = '0; count = '0;
        abort = 1'b0;
        test_reset();
        test_burst();
        test_clamp();
        test_continuous();
        test_back_to_back();
        test_max_count();
        test_async_reset();
`ifdef PULSE_TRAIN_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
